// File: rtl/char_rom_line_fetch_ctrl_if.sv
// Purpose: bundles the two requester handshakes, the returned code stream and
//          the character ROM read port of char_rom_line_fetch_ctrl.
// Ports:   master = overlay fillers + ROM (drive req/row/rom_data),
//          slave  = the fetch controller (drives gnt/vld/done/code/col/busy/rom_addr).
interface char_rom_line_fetch_ctrl_if #(
  parameter int ROW_W  = 4,
  parameter int COL_W  = 4,
  parameter int CODE_W = 7
);
  logic                   req_0;
  logic [ROW_W-1:0]       row_0;
  logic                   req_1;
  logic [ROW_W-1:0]       row_1;
  logic                   gnt_0;
  logic                   gnt_1;
  logic                   vld_0;
  logic                   vld_1;
  logic                   done_0;
  logic                   done_1;
  logic [CODE_W-1:0]      char_code_o;
  logic [COL_W-1:0]       col_o;
  logic                   busy;
  logic [ROW_W+COL_W-1:0] rom_addr;
  logic [CODE_W-1:0]      rom_data;

  modport master (
    output req_0, row_0, req_1, row_1, rom_data,
    input  gnt_0, gnt_1, vld_0, vld_1, done_0, done_1,
    input  char_code_o, col_o, busy, rom_addr
  );

  modport slave (
    input  req_0, row_0, req_1, row_1, rom_data,
    output gnt_0, gnt_1, vld_0, vld_1, done_0, done_1,
    output char_code_o, col_o, busy, rom_addr
  );
endinterface

// File: rtl/char_rom_line_fetch_ctrl.sv
// Purpose: arbitrates two text-overlay row fetches onto one character ROM and
//          streams a full 2**COL_W-column row back, each code tagged with its column.
// Ports:   clk, rst (async active-high) plus bus (slave modport): req/row in,
//          gnt/vld/done/char_code_o/col_o/busy out, rom_addr out, rom_data in.
// Latency: gnt one cycle after the IDLE request sample; code for column c appears
//          ROM_LAT+c cycles after gnt; done rides with the last column.
// Backpressure: none; requests are only looked at in IDLE, later ones wait.
// Build option: CHAR_ROM_CTRL_FIXED_PRIO_EN makes requester 0 win every tie
//          (default build is round-robin on ties).
module char_rom_line_fetch_ctrl #(
  parameter int ROW_W   = 4,
  parameter int COL_W   = 4,
  parameter int CODE_W  = 7,
  parameter int ROM_LAT = 1
) (
  input logic                      clk,
  input logic                      rst,
  char_rom_line_fetch_ctrl_if.slave bus
);

  localparam int AW     = ROW_W + COL_W;
  localparam int DCNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [COL_W-1:0] LAST_COL = {COL_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]     rom_addr_q;
  logic              owner_q;
  logic              gnt_0_q, gnt_1_q;
  logic [DCNT_W-1:0] drain_cnt_q;

  // issue tag travelling alongside the ROM read
  logic              tag_vld_q [ROM_LAT];
  logic              tag_own_q [ROM_LAT];
  logic [COL_W-1:0]  tag_col_q [ROM_LAT];

  logic              any_req;
  logic              pick_1;
  logic [ROW_W-1:0]  sel_row;
  logic              col_last;
  logic              drain_last;

  logic              grant;
  logic              busy_c;
  logic              issue_vld;

  assign any_req    = bus.req_0 | bus.req_1;
  assign col_last   = (rom_addr_q[COL_W-1:0] == LAST_COL);
  assign drain_last = (drain_cnt_q == DCNT_W'(ROM_LAT - 1));

`ifdef CHAR_ROM_CTRL_FIXED_PRIO_EN
  // requester 0 wins every tie; requester 1 only when alone
  assign pick_1 = bus.req_1 & ~bus.req_0;
`else
  logic last_owner_q;

  // on a tie, hand the ROM to whoever did not have it last
  assign pick_1 = bus.req_1 & (~bus.req_0 | ~last_owner_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_q <= 1'b1;
    end else if (grant) begin
      last_owner_q <= pick_1;
    end
  end
`endif

  assign sel_row = pick_1 ? bus.row_1 : bus.row_0;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)    state_d = BURST;
      BURST:   if (col_last)   state_d = DRAIN;
      DRAIN:   if (drain_last) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    grant     = 1'b0;
    busy_c    = 1'b0;
    issue_vld = 1'b0;
    case (state_q)
      IDLE:    grant     = any_req;
      BURST: begin
        busy_c    = 1'b1;
        issue_vld = 1'b1;
      end
      DRAIN:   busy_c    = 1'b1;
      default: busy_c    = 1'b0;
    endcase
  end

  // ---------------- burst datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_q  <= '0;
      owner_q     <= 1'b0;
      gnt_0_q     <= 1'b0;
      gnt_1_q     <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      gnt_0_q <= grant & ~pick_1;
      gnt_1_q <= grant &  pick_1;
      if (grant) begin
        owner_q    <= pick_1;
        rom_addr_q <= {sel_row, {COL_W{1'b0}}};
      end else if (state_q == BURST && !col_last) begin
        // column never carries into the row field: stops at LAST_COL
        rom_addr_q <= rom_addr_q + AW'(1);
      end
      if (state_q == BURST) begin
        drain_cnt_q <= '0;
      end else if (state_q == DRAIN) begin
        drain_cnt_q <= drain_cnt_q + DCNT_W'(1);
      end
    end
  end

  // ---------------- tag delay line, ROM_LAT deep ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_own_q[i] <= 1'b0;
        tag_col_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0] <= issue_vld;
      tag_own_q[0] <= owner_q;
      tag_col_q[0] <= rom_addr_q[COL_W-1:0];
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_own_q[i] <= tag_own_q[i-1];
        tag_col_q[i] <= tag_col_q[i-1];
      end
    end
  end

  // ---------------- returned stream ----------------
  logic             ret_vld;
  logic             ret_own;
  logic [COL_W-1:0] ret_col;

  assign ret_vld = tag_vld_q[ROM_LAT-1];
  assign ret_own = tag_own_q[ROM_LAT-1];
  assign ret_col = tag_col_q[ROM_LAT-1];

  assign bus.vld_0       = ret_vld & ~ret_own;
  assign bus.vld_1       = ret_vld &  ret_own;
  assign bus.done_0      = ret_vld & ~ret_own & (ret_col == LAST_COL);
  assign bus.done_1      = ret_vld &  ret_own & (ret_col == LAST_COL);
  assign bus.col_o       = ret_vld ? ret_col : '0;
  assign bus.char_code_o = ret_vld ? bus.rom_data : '0;

  assign bus.gnt_0    = gnt_0_q;
  assign bus.gnt_1    = gnt_1_q;
  assign bus.busy     = busy_c;
  assign bus.rom_addr = rom_addr_q;

endmodule
